// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by fetch (IF) and load/store (D).
// One grant per cycle, tracks the in-flight read and routes its data back to the owner.
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int READ_LAT   = 1,
    parameter int STREAK_MAX = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int LW = $clog2(READ_LAT + 1);
    localparam int SW = $clog2(STREAK_MAX + 1);

    typedef enum logic {IDLE, RD_WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          cancel_q, cancel_d;

    logic can_gnt, if_ok, if_force, deliver, rd_gnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IF;
            lat_q    <= '0;
            streak_q <= '0;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            lat_q    <= lat_d;
            streak_q <= streak_d;
            cancel_q <= cancel_d;
        end
    end

    always_comb begin
        // Grants are gated by reset so the port goes quiet the instant reset asserts.
        deliver  = (state_q == RD_WAIT) && (lat_q == LW'(1));
        can_gnt  = reset && ((state_q == IDLE) || deliver);
        if_ok    = if_req && !if_flush;
        if_force = if_ok && (streak_q == SW'(STREAK_MAX));
        if_gnt   = can_gnt && if_ok && (!d_req || if_force);
        d_gnt    = can_gnt && d_req && !if_force;
        rd_gnt   = if_gnt || (d_gnt && !d_we);

        if_rvalid = deliver && (owner_q == OWN_IF) && !cancel_q && !if_flush;
        d_rvalid  = deliver && (owner_q == OWN_D);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid  ? mem_rdata : '0;

        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (if_gnt) begin
            mem_addr = if_addr;
            mem_re   = 1'b1;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_we    = d_we;
            mem_re    = !d_we;
        end

        state_d  = state_q;
        owner_d  = owner_q;
        lat_d    = lat_q;
        cancel_d = cancel_q;
        if (state_q == RD_WAIT) begin
            // A flush kills the pending fetch response but the memory stays busy.
            if (owner_q == OWN_IF && if_flush)
                cancel_d = 1'b1;
            if (deliver) begin
                state_d = IDLE;
                lat_d   = '0;
            end else begin
                lat_d = lat_q - LW'(1);
            end
        end
        if (rd_gnt) begin
            state_d  = RD_WAIT;
            lat_d    = LW'(READ_LAT);
            owner_d  = if_gnt ? OWN_IF : OWN_D;
            cancel_d = 1'b0;
        end

        streak_d = streak_q;
        if (if_gnt || !if_req)
            streak_d = '0;
        else if (d_gnt && streak_q != SW'(STREAK_MAX))
            streak_d = streak_q + SW'(1);
    end
endmodule
